// File: rtl/spi_shifter_if.sv
// Request/response bundle between a frame producer and the SPI frame engine.
interface spi_shifter_if #(
   parameter int unsigned DATA_BITS = 48
);

   logic                 en;
   logic [DATA_BITS-1:0] data_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 ready;
   logic                 busy;
   logic                 done;

   // Producer side: issues frames, observes status and received data.
   modport master (
      output en,
      output data_in,
      input  data_out,
      input  ready,
      input  busy,
      input  done
   );

   // Engine side: accepts frames, reports status and received data.
   modport slave (
      input  en,
      input  data_in,
      output data_out,
      output ready,
      output busy,
      output done
   );

endinterface

// File: rtl/spi_shifter.sv
// Full-duplex SPI frame engine: launches tx bits on SCLK falling strobes,
// samples miso on SCLK rising strobes, frames start on slot boundaries.
module spi_shifter #(
   parameter int unsigned DATA_BITS  = 48,
   parameter int unsigned ALIGN_BITS = 8,
   parameter bit          LSB_FIRST  = 1'b0,
   parameter bit          IDLE_LEVEL = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sclk_posedge,
   input  logic         sclk_negedge,
   input  logic         miso,
   output logic         mosi,
   spi_shifter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
   localparam int unsigned ALN_W = (ALIGN_BITS > 1) ? $clog2(ALIGN_BITS) : 1;
   localparam logic [ALN_W-1:0] ALN_MAX  = ALN_W'(ALIGN_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SHIFT,
      ST_LAST
   } state_t;

   state_t               state_q, state_d;
   logic [ALN_W-1:0]     align_q, align_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_BITS-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 mosi_q, mosi_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic                 boundary_c;

   // Bit that goes on the wire first for a given tx word.
   function automatic logic first_bit(input logic [DATA_BITS-1:0] v);
      return LSB_FIRST ? v[0] : v[DATA_BITS-1];
   endfunction

   // Move the next tx bit into the launch position.
   function automatic logic [DATA_BITS-1:0] tx_advance(input logic [DATA_BITS-1:0] v);
      return LSB_FIRST ? (v >> 1) : (v << 1);
   endfunction

   // Insert a sampled bit so the first bit received ends in its natural slot.
   function automatic logic [DATA_BITS-1:0] rx_insert(input logic [DATA_BITS-1:0] v,
                                                      input logic                 b);
      logic [DATA_BITS-1:0] r;
      if (LSB_FIRST) begin
         r = v >> 1;
         r[DATA_BITS-1] = b;
      end else begin
         r = v << 1;
         r[0] = b;
      end
      return r;
   endfunction

   assign boundary_c = sclk_negedge && (align_q == '0);

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      align_d = align_q;
      cnt_d   = cnt_q;
      tx_sr_d = tx_sr_q;
      rx_sr_d = rx_sr_q;
      dout_d  = dout_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;

      if (sclk_negedge) begin
         align_d = (align_q == '0) ? ALN_MAX : (align_q - ALN_W'(1));
      end

      case (state_q)
         ST_IDLE: begin
            mosi_d = IDLE_LEVEL;
            if (bus.en) begin
               tx_sr_d = bus.data_in;
               cnt_d   = '0;
               state_d = ST_SYNC;
            end
         end

         ST_SYNC: begin
            if (boundary_c) begin
               mosi_d  = first_bit(tx_sr_q);
               tx_sr_d = tx_advance(tx_sr_q);
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (sclk_posedge) begin
               rx_sr_d = rx_insert(rx_sr_q, miso);
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == (CNT_FULL - CNT_W'(1))) begin
                  state_d = ST_LAST;
               end
            end
            // The final bit stays on the wire through LAST.
            if (sclk_negedge && (cnt_d < CNT_FULL)) begin
               mosi_d  = first_bit(tx_sr_q);
               tx_sr_d = tx_advance(tx_sr_q);
            end
         end

         ST_LAST: begin
            if (sclk_negedge) begin
               dout_d = rx_sr_q;
               done_d = 1'b1;
               if (bus.en && boundary_c) begin
                  tx_sr_d = tx_advance(bus.data_in);
                  mosi_d  = first_bit(bus.data_in);
                  cnt_d   = '0;
                  state_d = ST_SHIFT;
               end else begin
                  mosi_d  = IDLE_LEVEL;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            mosi_d  = IDLE_LEVEL;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         align_q <= ALN_MAX;
         cnt_q   <= '0;
         tx_sr_q <= '0;
         rx_sr_q <= '0;
         dout_q  <= '0;
         mosi_q  <= IDLE_LEVEL;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         align_q <= align_d;
         cnt_q   <= cnt_d;
         tx_sr_q <= tx_sr_d;
         rx_sr_q <= rx_sr_d;
         dout_q  <= dout_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign mosi         = mosi_q;
   assign bus.data_out = dout_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.ready    = ready_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: three configurations sharing one SCLK strobe source.
module tb_spi_shifter;

   localparam logic [47:0] CMD0 = 48'h400000000095;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sclk_posedge;
   logic        sclk_negedge;
   logic        miso;
   logic        mosi_m8, mosi_l8, mosi_48;
   logic        en_drv;
   logic [47:0] data_drv;
   int          sel;

   spi_shifter_if #(.DATA_BITS(8))  if_m8 ();
   spi_shifter_if #(.DATA_BITS(8))  if_l8 ();
   spi_shifter_if #(.DATA_BITS(48)) if_48 ();

   assign if_m8.en      = en_drv && (sel == 0);
   assign if_m8.data_in = data_drv[7:0];
   assign if_l8.en      = en_drv && (sel == 1);
   assign if_l8.data_in = data_drv[7:0];
   assign if_48.en      = en_drv && (sel == 2);
   assign if_48.data_in = data_drv;

   spi_shifter #(.DATA_BITS(8), .ALIGN_BITS(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_m8 (
      .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
      .miso(miso), .mosi(mosi_m8), .bus(if_m8));
   spi_shifter #(.DATA_BITS(8), .ALIGN_BITS(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_l8 (
      .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
      .miso(miso), .mosi(mosi_l8), .bus(if_l8));
   spi_shifter #(.DATA_BITS(48), .ALIGN_BITS(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_48 (
      .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
      .miso(miso), .mosi(mosi_48), .bus(if_48));

   // View of the currently selected instance.
   logic        mosi_s, done_s, busy_s, ready_s;
   logic [47:0] dout_s;
   always_comb begin
      case (sel)
         0: begin
            mosi_s = mosi_m8; done_s = if_m8.done; busy_s = if_m8.busy;
            ready_s = if_m8.ready; dout_s = {40'd0, if_m8.data_out};
         end
         1: begin
            mosi_s = mosi_l8; done_s = if_l8.done; busy_s = if_l8.busy;
            ready_s = if_l8.ready; dout_s = {40'd0, if_l8.data_out};
         end
         default: begin
            mosi_s = mosi_48; done_s = if_48.done; busy_s = if_48.busy;
            ready_s = if_48.ready; dout_s = if_48.data_out;
         end
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;

   // SCLK strobe phase and slot-counter model (all instances use 8 slots).
   int ph;
   int align_m;
   bit pos, neg, bnd;

   typedef struct {
      int          s;
      int unsigned n;
      bit          loop;
      bit          repulse;
      logic [47:0] data;
      logic [47:0] mseq;
      logic [47:0] exp_mosi;
      logic [47:0] exp_dout;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // One clk cycle: strobes applied at the falling clk edge, outputs sampled 1ns after rising.
   task automatic step();
      @(negedge clk);
      sclk_posedge = (ph == 0);
      sclk_negedge = (ph == 2);
      ph = (ph + 1) % 4;
      @(posedge clk);
      pos = sclk_posedge;
      neg = sclk_negedge;
      bnd = !reset && neg && (align_m == 0);
      if (reset) align_m = 7;
      else if (neg) align_m = (align_m == 0) ? 7 : align_m - 1;
      #1;
   endtask

   task automatic run_frame(input vec_t v, input int exp_lat, input string tag);
      int t, lat, posc, kbit, dones, extra;
      bit launched, idle_ok, stable_ok, finished;
      logic prev;
      logic [47:0] mo;
      sel = v.s;
      #1;
      t = 0;
      while (!ready_s && t < 100) begin step(); t++; end
      check({tag, "_ready_before"}, 96'(ready_s), 96'(1));
      data_drv = v.data;
      en_drv   = 1'b1;
      step();
      en_drv   = 1'b0;
      data_drv = '0;
      check({tag, "_busy_after_accept"}, 96'(busy_s), 96'(1));
      check({tag, "_ready_after_accept"}, 96'(ready_s), 96'(0));
      lat = 0; launched = 0; idle_ok = 1; t = 0;
      while (!launched && t < 64) begin
         miso = 1'b0;
         step(); t++;
         if (neg) lat++;
         if (bnd) launched = 1;
         else if (mosi_s !== 1'b1) idle_ok = 0;
      end
      check({tag, "_launched"}, 96'(launched), 96'(1));
      check({tag, "_idle_before_launch"}, 96'(idle_ok), 96'(1));
      if (exp_lat != 0) check({tag, "_launch_latency"}, 96'(lat), 96'(exp_lat));
      else check({tag, "_latency_in_range"}, 96'(lat >= 1 && lat <= 8), 96'(1));
      mo = '0;
      mo[v.n-1] = mosi_s;
      kbit = 1; posc = 0; dones = 0; stable_ok = 1; finished = 0; t = 0;
      prev = mosi_s;
      while (!finished && t < 1000) begin
         if (v.loop) miso = mosi_s;
         else miso = (posc < int'(v.n)) ? v.mseq[v.n-1-posc] : 1'b0;
         if (v.repulse) begin
            en_drv   = (posc >= 3 && posc < 6);
            data_drv = en_drv ? '1 : '0;
         end
         step(); t++;
         if (pos) posc++;
         if (neg && posc >= int'(v.n)) begin
            check({tag, "_done_pulse"}, 96'(done_s), 96'(1));
            check({tag, "_mosi_idle_after"}, 96'(mosi_s), 96'(1));
            check({tag, "_ready_after"}, 96'(ready_s), 96'(1));
            check({tag, "_data_out"}, 96'(dout_s), 96'(v.exp_dout));
            finished = 1;
         end else begin
            if (done_s) dones++;
            if (neg) begin
               if (kbit < int'(v.n)) mo[v.n-1-kbit] = mosi_s;
               kbit++;
            end else if (mosi_s !== prev) begin
               stable_ok = 0;
            end
         end
         prev = mosi_s;
      end
      en_drv   = 1'b0;
      data_drv = '0;
      check({tag, "_finished"}, 96'(finished), 96'(1));
      check({tag, "_mosi_stable_between_negedges"}, 96'(stable_ok), 96'(1));
      check({tag, "_no_early_done"}, 96'(dones), 96'(0));
      check({tag, "_mosi_bits"}, 96'(mo), 96'(v.exp_mosi));
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done_s) extra++;
      end
      check({tag, "_single_done"}, 96'(extra), 96'(0));
   endtask

   initial begin
      int t, posc, dones, idx, dcnt, negs_between;
      bit launched, ready_low;
      logic [95:0] got96;
      vec_t v;

      ph = 0; align_m = 7;
      reset = 1'b1; en_drv = 1'b0; data_drv = '0; miso = 1'b0; sel = 0;
      sclk_posedge = 1'b0; sclk_negedge = 1'b0;
      step(); step();
      reset = 1'b0;

      // Reset state of every instance.
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("reset_mosi_%0d", s),  96'(mosi_s),  96'(1));
         check($sformatf("reset_ready_%0d", s), 96'(ready_s), 96'(1));
         check($sformatf("reset_busy_%0d", s),  96'(busy_s),  96'(0));
         check($sformatf("reset_done_%0d", s),  96'(done_s),  96'(0));
         check($sformatf("reset_dout_%0d", s),  96'(dout_s),  96'(0));
      end

      vecs[0] = '{0, 8,  1'b1, 1'b0, 48'hA5, 48'h0,  48'hA5, 48'hA5};
      vecs[1] = '{1, 8,  1'b0, 1'b0, 48'h01, 48'hC0, 48'h80, 48'h03};
      vecs[2] = '{0, 8,  1'b0, 1'b1, 48'h3C, 48'h96, 48'h3C, 48'h96};
      vecs[3] = '{1, 8,  1'b0, 1'b0, 48'hC5, 48'h0F, 48'hA3, 48'hF0};
      vecs[4] = '{2, 48, 1'b1, 1'b0, CMD0,   48'h0,  CMD0,   CMD0};

      foreach (vecs[i]) run_frame(vecs[i], 0, $sformatf("vec%0d", i));

      // Acceptance while the slot counter sits at 3: four negedges to launch.
      sel = 0;
      t = 0;
      while (!(align_m == 3 && ph != 2) && t < 100) begin step(); t++; end
      v = '{0, 8, 1'b1, 1'b0, 48'h5A, 48'h0, 48'h5A, 48'h5A};
      run_frame(v, 4, "align3");

      // Reset in the middle of a 48-bit frame.
      sel = 2;
      #1;
      t = 0;
      while (!ready_s && t < 100) begin step(); t++; end
      data_drv = CMD0; en_drv = 1'b1;
      step();
      en_drv = 1'b0; data_drv = '0;
      posc = 0; dones = 0; t = 0;
      while (posc < 20 && t < 500) begin
         miso = mosi_s;
         step(); t++;
         if (pos) posc++;
         if (done_s) dones++;
      end
      check("midreset_busy_before", 96'(busy_s), 96'(1));
      reset = 1'b1;
      step();
      check("midreset_mosi",  96'(mosi_s),  96'(1));
      check("midreset_busy",  96'(busy_s),  96'(0));
      check("midreset_ready", 96'(ready_s), 96'(1));
      check("midreset_done",  96'(done_s),  96'(0));
      check("midreset_dout",  96'(dout_s),  96'(0));
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (done_s) dones++;
      end
      check("midreset_no_done", 96'(dones), 96'(0));
      run_frame(vecs[4], 0, "after_reset");

      // Two CMD0 frames back to back with en held high.
      sel = 2;
      #1;
      t = 0;
      while (!ready_s && t < 100) begin step(); t++; end
      data_drv = CMD0; en_drv = 1'b1;
      step();
      check("b2b_busy_after_accept", 96'(busy_s), 96'(1));
      launched = 0; t = 0;
      while (!launched && t < 64) begin
         miso = mosi_s;
         step(); t++;
         if (bnd) launched = 1;
      end
      check("b2b_launched", 96'(launched), 96'(1));
      got96 = '0;
      got96[95] = mosi_s;
      idx = 1; dcnt = 0; negs_between = 0; ready_low = 1; t = 0;
      while (dcnt < 2 && t < 2000) begin
         miso = mosi_s;
         step(); t++;
         if (dcnt == 1 && neg) negs_between++;
         if (done_s) begin
            dcnt++;
            if (dcnt == 1) begin
               en_drv = 1'b0;
               if (idx < 96) got96[95-idx] = mosi_s;
               idx++;
            end
         end else if (neg) begin
            if (idx < 96) got96[95-idx] = mosi_s;
            idx++;
         end
         if (dcnt < 2 && ready_s) ready_low = 0;
      end
      en_drv = 1'b0; data_drv = '0;
      check("b2b_done_count",   96'(dcnt),         96'(2));
      check("b2b_bit_count",    96'(idx),          96'(96));
      check("b2b_bits",         got96,             {CMD0, CMD0});
      check("b2b_done_spacing", 96'(negs_between), 96'(48));
      check("b2b_ready_low",    96'(ready_low),    96'(1));
      check("b2b_mosi_idle",    96'(mosi_s),       96'(1));
      check("b2b_dout",         96'(dout_s),       96'(CMD0));
      check("b2b_busy_end",     96'(busy_s),       96'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
